// File: rtl/spi_flash_emu.sv
// QSPI flash emulator: oversampled SPI slave serving 0x03/0x0B/0xEB/0x9F/0x05 reads
// from a preloadable word memory, with run-time QPI entry (0x38) and exit (0xFF).
module spi_flash_emu #(
  parameter int          ADDR_WIDTH   = 24,
  parameter int          MEM_WORDS    = 1024,
  parameter int          DUMMY_CYCLES = 8,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [23:0] JEDEC_ID     = 24'h010219
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_sck_i,
  input  logic                         spi_csn_i,
  input  logic [3:0]                   spi_sdi_i,
  output logic [3:0]                   spi_sdo_o,
  output logic [3:0]                   spi_oe_o,
  input  logic                         ld_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_addr_i,
  input  logic [31:0]                  ld_wdata_i,
  output logic                         ld_drop_o,
  output logic                         busy_o,
  output logic                         qpi_o,
  output logic [7:0]                   err_cnt_o
);
  localparam int          WAW   = $clog2(MEM_WORDS);
  localparam int          BAW   = WAW + 2;
  localparam logic [31:0] AMASK = 32'hFFFF_FFFF >> (32 - ADDR_WIDTH);

  localparam logic [7:0] OP_READ = 8'h03, OP_FAST = 8'h0B, OP_QREAD = 8'hEB;
  localparam logic [7:0] OP_RDID = 8'h9F, OP_RDSR = 8'h05, OP_EN4 = 8'h38, OP_EX4 = 8'hFF;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, UNSUP} state_t;
  typedef enum logic [1:0] {SRC_MEM, SRC_ID, SRC_STAT} src_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0]      sck_sync, csn_sync;
  logic [SYNC_STAGES-1:0][3:0] sdi_sync;
  logic sck_d, csn_d, sck, csn;
  logic sck_rise, sck_fall, csn_rise, csn_fall;
  logic [3:0] sdi;

  state_t state, state_n;
  src_t   src;
  logic [7:0]     cnt, need, op, tx, err, data_byte;
  logic [31:0]    sr, sr_n, rd_word;
  logic [BAW-1:0] addr;
  logic [3:0]     bits, sdo;
  logic [1:0]     id_idx, rd_sel;
  logic wide, quad_in, last, qpi, qpi_set, qpi_clr;
  logic [31:0] mem [MEM_WORDS];

  // Synchroniser and edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      csn_sync <= '1;
      sdi_sync <= '0;
      sck_d    <= 1'b0;
      csn_d    <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      csn_sync <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
      sck_d    <= sck;
      csn_d    <= csn;
    end
  end

  assign sck      = sck_sync[SYNC_STAGES-1];
  assign csn      = csn_sync[SYNC_STAGES-1];
  assign sdi      = sdi_sync[SYNC_STAGES-1];
  assign sck_rise = sck & ~sck_d;
  assign sck_fall = ~sck & sck_d;
  assign csn_rise = csn & ~csn_d;
  assign csn_fall = ~csn & csn_d;

  assign busy_o    = ~csn;
  assign ld_drop_o = ld_we_i & busy_o;
  assign qpi_o     = qpi;
  assign err_cnt_o = err;
  assign spi_sdo_o = sdo;
  assign spi_oe_o  = (state == DATA) ? (wide ? 4'b1111 : 4'b0010) : 4'b0000;

  always_comb begin
    quad_in = (state == CMD) ? qpi : wide;
    sr_n    = quad_in ? {sr[27:0], sdi} : {sr[30:0], sdi[0]};
    case (state)
      CMD:     need = qpi ? 8'd2 : 8'd8;
      ADDR:    need = wide ? 8'(ADDR_WIDTH / 4) : 8'(ADDR_WIDTH);
      MODE:    need = 8'd2;
      DUMMY:   need = 8'(DUMMY_CYCLES);
      default: need = 8'd0;
    endcase
    last    = sck_rise && (cnt == need - 8'd1);
    state_n = state;
    if (csn_rise) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (csn_fall) state_n = CMD;
        CMD: if (last) begin
          case (sr_n[7:0])
            OP_READ, OP_FAST, OP_QREAD: state_n = ADDR;
            OP_RDID, OP_RDSR:           state_n = DATA;
            OP_EN4, OP_EX4:             state_n = IDLE;
            default:                    state_n = UNSUP;
          endcase
        end
        ADDR: if (last) begin
          if (op == OP_READ)       state_n = DATA;
          else if (op == OP_QREAD) state_n = MODE;
          else                     state_n = (DUMMY_CYCLES > 0) ? DUMMY : DATA;
        end
        MODE:    if (last) state_n = (DUMMY_CYCLES > 0) ? DUMMY : DATA;
        DUMMY:   if (last) state_n = DATA;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    case (src)
      SRC_ID: begin
        case (id_idx)
          2'd0:    data_byte = JEDEC_ID[23:16];
          2'd1:    data_byte = JEDEC_ID[15:8];
          default: data_byte = JEDEC_ID[7:0];
        endcase
      end
      SRC_STAT: data_byte = {6'b0, qpi, 1'b0};
      default:  data_byte = rd_word[{rd_sel, 3'b000} +: 8];
    endcase
  end

  // Backing store: rd_word tracks addr continuously, so the next byte is ready before its first fall
  always_ff @(posedge clk) begin
    if (ld_we_i && !busy_o) mem[ld_addr_i] <= ld_wdata_i;
    rd_word <= mem[addr[BAW-1:2]];
    rd_sel  <= addr[1:0];
  end

  // Command/address capture and output shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; sr <= '0; op <= '0; wide <= 1'b0; addr <= '0; tx <= '0; bits <= '0;
      src <= SRC_MEM; id_idx <= '0; qpi <= 1'b0; qpi_set <= 1'b0; qpi_clr <= 1'b0;
      err <= '0; sdo <= '0;
    end else if (csn_rise) begin
      cnt     <= '0;
      bits    <= '0;
      sdo     <= '0;
      qpi_set <= 1'b0;
      qpi_clr <= 1'b0;
      if (qpi_set)      qpi <= 1'b1;
      else if (qpi_clr) qpi <= 1'b0;
    end else begin
      if (state_n != state) cnt <= '0;
      else if (sck_rise)    cnt <= cnt + 8'd1;
      if (sck_rise && (state == CMD || state == ADDR || state == MODE)) sr <= sr_n;
      if (state == CMD && last) begin
        op     <= sr_n[7:0];
        wide   <= qpi | (sr_n[7:0] == OP_QREAD);
        id_idx <= '0;
        src    <= (sr_n[7:0] == OP_RDSR) ? SRC_STAT : SRC_ID;
        case (sr_n[7:0])
          OP_EN4:                                       qpi_set <= 1'b1;
          OP_EX4:                                       qpi_clr <= 1'b1;
          OP_READ, OP_FAST, OP_QREAD, OP_RDID, OP_RDSR: ;
          default:                                      err <= sat_inc(err);
        endcase
      end
      if (state == ADDR && last) begin
        addr <= BAW'(sr_n & AMASK);
        src  <= SRC_MEM;
      end
      if (state != DATA) begin
        bits <= '0;
      end else if (sck_fall) begin
        if (bits == 4'd0) begin
          if (wide) begin
            sdo  <= data_byte[7:4];
            tx   <= {data_byte[3:0], 4'b0};
            bits <= 4'd4;
          end else begin
            sdo  <= {2'b00, data_byte[7], 1'b0};
            tx   <= {data_byte[6:0], 1'b0};
            bits <= 4'd7;
          end
          addr   <= addr + 1'b1;
          id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
        end else if (wide) begin
          sdo  <= tx[7:4];
          tx   <= {tx[3:0], 4'b0};
          bits <= bits - 4'd4;
        end else begin
          sdo  <= {2'b00, tx[7], 1'b0};
          tx   <= {tx[6:0], 1'b0};
          bits <= bits - 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_emu.sv
// Directed bench for spi_flash_emu: a mode-0 SPI master drives commands while a byte
// scoreboard holds the expected read data derived from a model of the preloaded memory.
module tb_spi_flash_emu;
  localparam int HALF = 80;

  logic       clk = 1'b0, rst = 1'b1, sck = 1'b0, csn = 1'b1;
  logic [3:0] sdi = 4'h0;
  logic [3:0] sdo, oe;
  logic       ld_we = 1'b0;
  logic [9:0] ld_addr = '0;
  logic [31:0] ld_wdata = '0;
  logic       ld_drop, busy, qpi;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [1024];
  logic [7:0]  exp_q [$];

  spi_flash_emu dut (
    .clk(clk), .rst(rst), .spi_sck_i(sck), .spi_csn_i(csn), .spi_sdi_i(sdi),
    .spi_sdo_o(sdo), .spi_oe_o(oe), .ld_we_i(ld_we), .ld_addr_i(ld_addr),
    .ld_wdata_i(ld_wdata), .ld_drop_o(ld_drop), .busy_o(busy), .qpi_o(qpi),
    .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [11:0] a);
    logic [31:0] w;
    w = mdl[a[11:2]];
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic push_mem(input logic [11:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_byte(a + 12'(i)));
  endtask

  task automatic cyc(input logic [3:0] d);
    sdi = d; #HALF; sck = 1'b1; #HALF; sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit quad);
    if (quad) begin
      cyc(b[7:4]); cyc(b[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) cyc({3'b000, b[i]});
    end
  endtask

  task automatic send_addr(input logic [23:0] a, input bit quad);
    send_byte(a[23:16], quad); send_byte(a[15:8], quad); send_byte(a[7:0], quad);
  endtask

  task automatic dummy(input int n);
    for (int i = 0; i < n; i++) cyc(4'h0);
  endtask

  task automatic read_byte(input bit quad, input string tag);
    logic [7:0] b;
    logic [7:0] e;
    b = '0;
    for (int i = 0; i < (quad ? 2 : 8); i++) begin
      #HALF;
      if (quad) b = {b[3:0], sdo};
      else      b = {b[6:0], sdo[1]};
      if (i == 0) check({tag, "_oe"}, 32'(oe), quad ? 32'hF : 32'h2);
      sck = 1'b1; #HALF; sck = 1'b0;
    end
    e = exp_q.pop_front();
    check(tag, 32'(b), 32'(e));
  endtask

  task automatic cs_low();
    csn = 1'b0; #HALF;
  endtask

  task automatic cs_high();
    #HALF; csn = 1'b1; #(4 * HALF);
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d, input bit drop);
    ld_addr = a; ld_wdata = d; ld_we = 1'b1;
    #2;
    check("ld_drop", 32'(ld_drop), 32'(drop));
    #8;
    ld_we = 1'b0;
    if (!drop) mdl[a] = d;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sdo", 32'(sdo), 0);
    check("rst_oe", 32'(oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_qpi", 32'(qpi), 0);
    check("rst_err", 32'(err_cnt), 0);
    check("rst_drop", 32'(ld_drop), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    preload(10'd0, 32'h44332211, 1'b0);
    preload(10'd1, 32'h88776655, 1'b0);
    preload(10'd2, 32'hAABBCCDD, 1'b0);
    preload(10'd1023, $urandom, 1'b0);

    // single-line READ from byte 1
    cs_low();
    check("busy_low", 32'(busy), 1);
    send_byte(8'h03, 1'b0); send_addr(24'h000001, 1'b0);
    push_mem(12'h001, 4);
    repeat (4) read_byte(1'b0, "read");
    cs_high();
    check("oe_after_read", 32'(oe), 0);

    // FAST_READ wrapping past the top of memory
    cs_low();
    send_byte(8'h0B, 1'b0); send_addr(24'h000FFE, 1'b0); dummy(8);
    push_mem(12'hFFE, 3);
    repeat (3) read_byte(1'b0, "wrap");
    cs_high();

    // QPI entry, status, quad read, exit
    cs_low(); send_byte(8'h38, 1'b0);
    check("qpi_before_csn", 32'(qpi), 0);
    cs_high();
    check("qpi_on", 32'(qpi), 1);
    cs_low(); send_byte(8'h05, 1'b1);
    exp_q.push_back(8'h02); exp_q.push_back(8'h02);
    repeat (2) read_byte(1'b1, "status");
    cs_high();
    cs_low(); send_byte(8'hEB, 1'b1); send_addr(24'h000004, 1'b1); dummy(2); dummy(8);
    push_mem(12'h004, 2);
    repeat (2) read_byte(1'b1, "qread");
    cs_high();
    cs_low(); send_byte(8'hFF, 1'b1); cs_high();
    check("qpi_off", 32'(qpi), 0);

    // unsupported opcode
    cs_low(); send_byte(8'h02, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(4'h1);
      check("unsup_oe", 32'(oe), 0);
    end
    cs_high();
    check("err_cnt", 32'(err_cnt), 1);

    // READ abandoned after 12 address bits, then JEDEC ID
    cs_low(); send_byte(8'h03, 1'b0);
    for (int i = 0; i < 12; i++) cyc(4'h1);
    cs_high();
    check("abort_oe", 32'(oe), 0);
    check("abort_err", 32'(err_cnt), 1);
    cs_low(); send_byte(8'h9F, 1'b0);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h19); exp_q.push_back(8'h01);
    repeat (4) read_byte(1'b0, "jedec");
    cs_high();

    // preload collision then accepted write
    cs_low();
    preload(10'd2, 32'h12345678, 1'b1);
    cs_high();
    cs_low(); send_byte(8'h03, 1'b0); send_addr(24'h000008, 1'b0);
    push_mem(12'h008, 4);
    repeat (4) read_byte(1'b0, "dropped");
    cs_high();
    preload(10'd2, 32'h12345678, 1'b0);
    cs_low(); send_byte(8'h03, 1'b0); send_addr(24'h000008, 1'b0);
    push_mem(12'h008, 4);
    repeat (4) read_byte(1'b0, "written");
    cs_high();

    // reset in the middle of a quad read
    cs_low(); send_byte(8'h38, 1'b0); cs_high();
    check("qpi_on2", 32'(qpi), 1);
    cs_low(); send_byte(8'hEB, 1'b1); send_addr(24'h000000, 1'b1); dummy(2); dummy(8);
    push_mem(12'h000, 1);
    read_byte(1'b1, "pre_rst");
    #20;
    check("pre_rst_oe", 32'(oe), 32'hF);
    rst = 1'b1;
    #1;
    check("mid_rst_sdo", 32'(sdo), 0);
    check("mid_rst_oe", 32'(oe), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_qpi", 32'(qpi), 0);
    check("mid_rst_err", 32'(err_cnt), 0);
    #9;
    csn = 1'b1;
    #(4 * HALF);
    rst = 1'b0;
    #(4 * HALF);
    check("post_rst_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
